// File: rtl/counter_pkg.sv
// Shared constants and types for the programmable counter family.
package counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic {
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/counter_next.sv
// Combinational next-count and overflow detection for up/down counters.
module counter_next
    import counter_pkg::*;
#(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic [N-1:0]      i_q,
    input  logic [N-1:0]      i_limit,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_up,
    input  logic [1:0]        i_mode,
    output logic [N-1:0]      o_q_next,
    output logic              o_ovf
);

    localparam logic [N:0] ONE = 1;

    logic [N:0] w_q;
    logic [N:0] w_lim;
    logic [N:0] w_stp;
    logic [N:0] w_se;
    logic [N:0] w_sum;
    logic       w_clamp;

    assign w_q     = {1'b0, i_q};
    assign w_lim   = {1'b0, i_limit};
    assign w_stp   = {{(N+1-STEP_W){1'b0}}, i_step};
    assign w_se    = (w_stp > w_lim) ? w_lim : w_stp;
    assign w_sum   = w_q + w_se;
    assign w_clamp = (i_mode == MODE_SAT) || (i_mode == MODE_ONESHOT);

    always_comb begin
        o_q_next = i_q;
        o_ovf    = 1'b0;
        // A zero effective step only counts as overflow when the range is {0}.
        if (w_se == '0) begin
            o_ovf = (i_limit == '0);
        end else if (i_up) begin
            if (w_sum > w_lim) begin
                o_ovf    = 1'b1;
                o_q_next = w_clamp ? i_limit : N'(w_sum - w_lim - ONE);
            end else begin
                o_q_next = N'(w_sum);
            end
        end else begin
            if (w_q < w_se) begin
                o_ovf    = 1'b1;
                o_q_next = w_clamp ? '0 : N'(w_q + w_lim + ONE - w_se);
            end else begin
                o_q_next = N'(w_q - w_se);
            end
        end
    end

endmodule

// File: rtl/counter_ud_prog.sv
// Programmable up/down counter with wrap, saturate and one-shot modes.
module counter_ud_prog
    import counter_pkg::*;
#(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_up,
    input  logic              i_load,
    input  logic [N-1:0]      i_load_val,
    input  logic [N-1:0]      i_limit,
    input  logic [STEP_W-1:0] i_step,
    input  logic [1:0]        i_mode,
    output logic [N-1:0]      o_q,
    output logic              o_tc,
    output logic              o_done
);

    logic [N-1:0] r_q;
    logic         r_tc;
    logic         r_done;
    state_t       r_state;

    logic [N-1:0] w_q_next;
    logic         w_ovf;
    logic         w_oneshot;

    assign w_oneshot = (i_mode == MODE_ONESHOT);

    counter_next #(
        .N      (N),
        .STEP_W (STEP_W)
    ) u_next (
        .i_q      (r_q),
        .i_limit  (i_limit),
        .i_step   (i_step),
        .i_up     (i_up),
        .i_mode   (i_mode),
        .o_q_next (w_q_next),
        .o_ovf    (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q     <= '0;
            r_tc    <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_RUN;
        end else if (i_load) begin
            r_q     <= (i_load_val > i_limit) ? i_limit : i_load_val;
            r_tc    <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_RUN;
        end else if (r_state == ST_DONE || !i_en) begin
            r_tc    <= 1'b0;
        end else if (r_q > i_limit) begin
            // Limit was lowered below the current count.
            r_q     <= i_limit;
            r_tc    <= 1'b1;
            if (w_oneshot) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
            end
        end else begin
            r_q     <= w_q_next;
            r_tc    <= w_ovf;
            if (w_oneshot && w_ovf) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
            end
        end
    end

    assign o_q    = r_q;
    assign o_tc   = r_tc;
    assign o_done = r_done;

endmodule

// File: tb/tb_counter_ud_prog.sv
// Directed self-checking bench for counter_ud_prog.
module tb_counter_ud_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_en;
    logic       i_up;
    logic       i_load;
    logic [7:0] i_load_val;
    logic [7:0] i_limit;
    logic [3:0] i_step;
    logic [1:0] i_mode;
    logic [7:0] o_q;
    logic       o_tc;
    logic       o_done;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    counter_ud_prog #(.N(8), .STEP_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (i_en),
        .i_up       (i_up),
        .i_load     (i_load),
        .i_load_val (i_load_val),
        .i_limit    (i_limit),
        .i_step     (i_step),
        .i_mode     (i_mode),
        .o_q        (o_q),
        .o_tc       (o_tc),
        .o_done     (o_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] eq,
                       input logic etc, input logic ed);
        n_total++;
        assert (o_q === eq && o_tc === etc && o_done === ed)
            n_pass++;
        else
            $error("FAIL %s: got q=%0d tc=%b done=%b, want q=%0d tc=%b done=%b",
                   tag, o_q, o_tc, o_done, eq, etc, ed);
    endtask

    task automatic do_load(input logic [7:0] v);
        i_load = 1'b1;
        i_load_val = v;
        tick();
        i_load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_en = 1'b0; i_up = 1'b1; i_load = 1'b0;
        i_load_val = 8'd0; i_limit = 8'd9; i_step = 4'd3; i_mode = 2'b00;
        tick();
        chk("reset", 8'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Wrap up
        do_load(8'd0);
        chk("wu_load", 8'd0, 1'b0, 1'b0);
        i_en = 1'b1;
        tick(); chk("wu_3", 8'd3, 1'b0, 1'b0);
        tick(); chk("wu_6", 8'd6, 1'b0, 1'b0);
        tick(); chk("wu_9", 8'd9, 1'b0, 1'b0);
        tick(); chk("wu_2", 8'd2, 1'b1, 1'b0);
        i_en = 1'b0;
        tick(); chk("wu_hold", 8'd2, 1'b0, 1'b0);

        // Wrap down
        i_up = 1'b0; i_step = 4'd4;
        do_load(8'd2);
        chk("wd_load", 8'd2, 1'b0, 1'b0);
        i_en = 1'b1;
        tick(); chk("wd_8", 8'd8, 1'b1, 1'b0);
        tick(); chk("wd_4", 8'd4, 1'b0, 1'b0);
        i_en = 1'b0;

        // Saturate
        i_up = 1'b1; i_mode = 2'b01; i_limit = 8'd200; i_step = 4'd15;
        do_load(8'd190);
        chk("sat_load", 8'd190, 1'b0, 1'b0);
        i_en = 1'b1;
        tick(); chk("sat_hit", 8'd200, 1'b1, 1'b0);
        tick(); chk("sat_stay", 8'd200, 1'b1, 1'b0);
        i_en = 1'b0;
        tick(); chk("sat_idle", 8'd200, 1'b0, 1'b0);

        // One-shot down
        i_up = 1'b0; i_mode = 2'b10; i_limit = 8'd50; i_step = 4'd2;
        do_load(8'd5);
        chk("os_load", 8'd5, 1'b0, 1'b0);
        i_en = 1'b1;
        tick(); chk("os_3", 8'd3, 1'b0, 1'b0);
        tick(); chk("os_1", 8'd1, 1'b0, 1'b0);
        tick(); chk("os_0", 8'd0, 1'b1, 1'b1);
        tick(); chk("os_done1", 8'd0, 1'b0, 1'b1);
        tick(); chk("os_done2", 8'd0, 1'b0, 1'b1);
        i_mode = 2'b00;
        tick(); chk("os_modechg", 8'd0, 1'b0, 1'b1);
        i_mode = 2'b10; i_en = 1'b0;
        do_load(8'd7);
        chk("os_reload", 8'd7, 1'b0, 1'b0);
        i_en = 1'b1;
        tick(); chk("os_resume", 8'd5, 1'b0, 1'b0);
        i_en = 1'b0;

        // Range clamping
        i_mode = 2'b00; i_up = 1'b1; i_limit = 8'd100;
        do_load(8'd250);
        chk("clamp_load", 8'd100, 1'b0, 1'b0);
        do_load(8'd80);
        i_limit = 8'd50; i_en = 1'b1;
        tick(); chk("clamp_oor", 8'd50, 1'b1, 1'b0);
        i_en = 1'b0; i_limit = 8'd5; i_step = 4'd12;
        do_load(8'd0);
        i_en = 1'b1;
        tick(); chk("stepeff_5", 8'd5, 1'b0, 1'b0);
        tick(); chk("stepeff_wrap", 8'd4, 1'b1, 1'b0);
        i_en = 1'b0; i_limit = 8'd0;
        do_load(8'd3);
        chk("lim0_load", 8'd0, 1'b0, 1'b0);
        i_en = 1'b1;
        tick(); chk("lim0_tc", 8'd0, 1'b1, 1'b0);
        i_en = 1'b0;

        // Priorities
        i_mode = 2'b10; i_limit = 8'd10; i_step = 4'd5;
        do_load(8'd0);
        i_en = 1'b1;
        tick(); chk("pr_5", 8'd5, 1'b0, 1'b0);
        tick(); chk("pr_10", 8'd10, 1'b0, 1'b0);
        tick(); chk("pr_done", 8'd10, 1'b1, 1'b1);
        rst = 1'b1; i_load = 1'b1; i_load_val = 8'd7;
        tick(); chk("pr_rst_all", 8'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(); chk("pr_load_en", 8'd7, 1'b0, 1'b0);
        i_load = 1'b0;
        tick(); chk("pr_done2", 8'd10, 1'b1, 1'b1);
        rst = 1'b1;
        tick(); chk("pr_rst_done", 8'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(); chk("pr_run", 8'd5, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
